// File: rtl/prog_clk_ctrl_if.sv
// Configuration channel for prog_clk_ctrl: valid/ready transfer of a
// period/high-time pair, plus a one-cycle reject pulse back to the producer.
interface prog_clk_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_ton;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_period, cfg_ton, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_period, cfg_ton, output cfg_ready, cfg_err);
endinterface

// File: rtl/prog_clk_ctrl.sv
// Programmable divided clock: period and high time in clk cycles, low phase
// first. New settings are staged in a pending slot and only promoted to the
// active registers while idle or on the last cycle of a period, so the
// generated waveform never carries a runt pulse.
module prog_clk_ctrl #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_TON    = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  prog_clk_ctrl_if.slave     cfg,
  output logic               clk_out,
  output logic               period_start,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_ton_q, act_ton_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_ton_q, pend_ton_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             ps_q, ps_d;
  logic             err_q, err_d;
  logic             xfer, cfg_ok, boundary, apply, run_d;

  // Handshake: a single pending slot, so ready is simply "slot empty".
  assign cfg.cfg_ready = !pend_v_q;
  assign cfg.cfg_err   = err_q;
  assign xfer     = cfg.cfg_valid && !pend_v_q;
  // ton < period also guarantees period - ton never underflows.
  assign cfg_ok   = (cfg.cfg_period >= TWO) && (cfg.cfg_ton != '0) &&
                    (cfg.cfg_ton < cfg.cfg_period);
  assign boundary = (state_q != IDLE) && (cnt_q == act_period_q - ONE);
  // Promote staged config only where it cannot cut a period short.
  assign apply    = pend_v_q && ((state_q == IDLE) || boundary);

  assign clk_out      = clk_out_q;
  assign period_start = ps_q;
  assign busy         = (state_q != IDLE);

  // Config staging: accept/reject transfers and promote pending to active.
  always_comb begin
    pend_period_d = pend_period_q;
    pend_ton_d    = pend_ton_q;
    pend_v_d      = pend_v_q;
    act_period_d  = act_period_q;
    act_ton_d     = act_ton_q;
    err_d         = 1'b0;
    if (xfer) begin
      if (cfg_ok) begin
        pend_period_d = cfg.cfg_period;
        pend_ton_d    = cfg.cfg_ton;
        pend_v_d      = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // xfer needs an empty slot and apply a full one, so they never collide.
    if (apply) begin
      act_period_d = pend_period_q;
      act_ton_d    = pend_ton_q;
      pend_v_d     = 1'b0;
    end
  end

  // Next state, counter, and the registered waveform for the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        cnt_d = boundary ? '0 : cnt_q + ONE;
        if (!en) state_d = STOP;
      end
      STOP: begin
        cnt_d = boundary ? '0 : cnt_q + ONE;
        if (en)            state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are computed from next-cycle values so they leave a flop.
    run_d     = (state_d != IDLE);
    clk_out_d = run_d && (cnt_d >= act_period_d - act_ton_d);
    ps_d      = run_d && (cnt_d == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; reset drops any staged config and restores defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_ton_q     <= CNT_W'(DEF_TON);
      pend_period_q <= '0;
      pend_ton_q    <= '0;
      pend_v_q      <= 1'b0;
      clk_out_q     <= 1'b0;
      ps_q          <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      act_period_q  <= act_period_d;
      act_ton_q     <= act_ton_d;
      pend_period_q <= pend_period_d;
      pend_ton_q    <= pend_ton_d;
      pend_v_q      <= pend_v_d;
      clk_out_q     <= clk_out_d;
      ps_q          <= ps_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_clk_ctrl.sv
// Scoreboard bench for prog_clk_ctrl: each stimulus cycle pushes the
// hand-derived outputs for the following cycle; a negedge monitor pops and
// compares them against the DUT.
module tb_prog_clk_ctrl;

  typedef struct packed {
    logic clk_o;
    logic ps;
    logic busy;
    logic rdy;
    logic err;
  } exp_t;

  logic clk, rst_n, en;
  logic clk_out, period_start, busy;
  int   n_chk, n_pass, cyc_n;
  exp_t exp_q[$];

  prog_clk_ctrl_if #(.CNT_W(16)) cfg_if ();

  prog_clk_ctrl #(.CNT_W(16), .DEF_PERIOD(10), .DEF_TON(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg          (cfg_if),
    .clk_out      (clk_out),
    .period_start (period_start),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0b exp=%0b", name, cyc_n, act, exp);
  endtask

  // Expected outputs in a running period: low for the first p-t cycles.
  function automatic exp_t er(input int c, input int p, input int t,
                              input bit rdy, input bit err = 1'b0);
    exp_t e;
    e.clk_o = (c >= p - t);
    e.ps    = (c == 0);
    e.busy  = 1'b1;
    e.rdy   = rdy;
    e.err   = err;
    return e;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e = '{clk_o: 1'b0, ps: 1'b0, busy: 1'b0, rdy: 1'b1, err: 1'b0};
    return e;
  endfunction

  // Drive inputs for the next edge, then queue what that edge must produce.
  task automatic cyc(input bit en_v, input bit cv, input int p, input int t, input exp_t e);
    en               = en_v;
    cfg_if.cfg_valid = cv;
    cfg_if.cfg_period = 16'(p);
    cfg_if.cfg_ton    = 16'(t);
    @(posedge clk);
    #1;
    cyc_n++;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input int start, input int p, input int t);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, er((start + i) % p, p, t, 1'b1));
  endtask

  // Transfer (np,nt) at the edge into cnt=1 of a (p,t) period; shows that period.
  task automatic recfg(input int p, input int t, input int np, input int nt);
    cyc(1'b1, 1'b0, 0, 0, er(0, p, t, 1'b1));
    cyc(1'b1, 1'b1, np, nt, er(1, p, t, 1'b0));
    for (int c = 2; c < p; c++) cyc(1'b1, 1'b0, 0, 0, er(c, p, t, 1'b0));
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("clk_out",      clk_out,          e.clk_o);
      chk("period_start", period_start,     e.ps);
      chk("busy",         busy,             e.busy);
      chk("cfg_ready",    cfg_if.cfg_ready, e.rdy);
      chk("cfg_err",      cfg_if.cfg_err,   e.err);
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc_n = 0;
    rst_n = 1'b0; en = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0; cfg_if.cfg_ton = '0;
    #1;
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_ps",      period_start, 1'b0);
    chk("rst_busy",    busy, 1'b0);
    chk("rst_ready",   cfg_if.cfg_ready, 1'b1);
    chk("rst_err",     cfg_if.cfg_err, 1'b0);
    #11 rst_n = 1'b1;

    // Default 10/7 from IDLE: 3 low, 7 high, period_start on cnt=0.
    cyc(1'b0, 1'b0, 0, 0, idle_e());
    cyc(1'b0, 1'b0, 0, 0, idle_e());
    run(20, 0, 10, 7);

    // (4,1) offered during cnt=5: current period finishes as 10/7.
    for (int c = 0; c <= 5; c++) cyc(1'b1, 1'b0, 0, 0, er(c, 10, 7, 1'b1));
    cyc(1'b1, 1'b1, 4, 1, er(6, 10, 7, 1'b0));
    for (int c = 7; c <= 9; c++) cyc(1'b1, 1'b0, 0, 0, er(c, 10, 7, 1'b0));
    run(12, 0, 4, 1);

    // Back to 10/7, then (4,1) in the boundary cycle and (6,3) held behind it.
    recfg(4, 1, 10, 7);
    run(10, 0, 10, 7);
    cyc(1'b1, 1'b1, 4, 1, er(0, 10, 7, 1'b0));
    for (int c = 1; c <= 9; c++) cyc(1'b1, 1'b1, 6, 3, er(c, 10, 7, 1'b0));
    cyc(1'b1, 1'b1, 6, 3, er(0, 4, 1, 1'b1));
    cyc(1'b1, 1'b1, 6, 3, er(1, 4, 1, 1'b0));
    cyc(1'b1, 1'b0, 0, 0, er(2, 4, 1, 1'b0));
    cyc(1'b1, 1'b0, 0, 0, er(3, 4, 1, 1'b0));
    run(12, 0, 6, 3);

    // Rejected configs: each pulses cfg_err, 10/7 waveform stays intact.
    recfg(6, 3, 10, 7);
    run(2, 0, 10, 7);
    cyc(1'b1, 1'b1, 5, 0, er(2, 10, 7, 1'b1, 1'b1));
    cyc(1'b1, 1'b1, 1, 1, er(3, 10, 7, 1'b1, 1'b1));
    cyc(1'b1, 1'b1, 5, 5, er(4, 10, 7, 1'b1, 1'b1));
    run(5, 5, 10, 7);
    run(10, 0, 10, 7);

    // en dropped at cnt=4: high phase completes, IDLE after cnt=9.
    run(5, 0, 10, 7);
    for (int c = 5; c <= 9; c++) cyc(1'b0, 1'b0, 0, 0, er(c, 10, 7, 1'b1));
    cyc(1'b0, 1'b0, 0, 0, idle_e());
    cyc(1'b0, 1'b0, 0, 0, idle_e());

    // en dropped then re-raised before the boundary: no gap, no extra start.
    run(4, 0, 10, 7);
    for (int c = 4; c <= 6; c++) cyc(1'b0, 1'b0, 0, 0, er(c, 10, 7, 1'b1));
    run(3, 7, 10, 7);
    run(10, 0, 10, 7);

    // Async reset mid-high phase with a staged (4,1) that must be discarded.
    run(2, 0, 10, 7);
    cyc(1'b1, 1'b1, 4, 1, er(2, 10, 7, 1'b0));
    for (int c = 3; c <= 5; c++) cyc(1'b1, 1'b0, 0, 0, er(c, 10, 7, 1'b0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk_out", clk_out, 1'b0);
    chk("arst_ps",      period_start, 1'b0);
    chk("arst_busy",    busy, 1'b0);
    chk("arst_ready",   cfg_if.cfg_ready, 1'b1);
    chk("arst_err",     cfg_if.cfg_err, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(20, 0, 10, 7);

    // Every queued expectation must have been consumed by the monitor.
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_clk_ctrl.md
Name: prog_clk_ctrl

Overview:
- Synthesizable controller that generates a divided, duty-cycle-programmable clock (`clk_out`) from the system clock.
- Period and high time are specified in input-clock cycles, replacing the real-valued freq/duty delay loop used in simulation.
- Configuration arrives over a valid/ready handshake and is applied glitch-free at period boundaries. Start and stop are sequenced by `en`.
- Sits between the register/config logic and any block needing a slow strobe or test clock.

Parameters:
- CNT_W, 16, width of the period/ton counters and config fields.
- DEF_PERIOD, 10, active period loaded at reset (input clk cycles).
- DEF_TON, 7, active high time loaded at reset (70% duty).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request; level-sensitive.
- cfg_valid  input  1  new configuration offered.
- cfg_period  input  CNT_W  requested period, in clk cycles.
- cfg_ton  input  CNT_W  requested high time, in clk cycles.
- cfg_ready  output  1  controller can accept a configuration.
- cfg_err  output  1  one-cycle pulse: offered config rejected.
- clk_out  output  1  generated clock, registered.
- period_start  output  1  one-cycle pulse on the first cycle of each generated period.
- busy  output  1  high in RUN or STOP state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, clk_out=0, period_start=0, cfg_err=0, busy=0.
  - act_period=DEF_PERIOD, act_ton=DEF_TON, pend_v=0, cfg_ready=1.
  - Outputs clear immediately, without waiting for a clock edge. Reset mid-period abandons the period; no partial config survives.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready at a rising edge. cfg_ready = !pend_v (registered).
  - Valid config: cfg_period >= 2 and 1 <= cfg_ton <= cfg_period-1. A valid transfer stores the values into the pending registers and sets pend_v.
  - Invalid config: the transfer is still consumed; cfg_err=1 in the following cycle; pending and active registers are unchanged.
- Applying pending config:
  - In IDLE, pending is copied to active on the next edge and pend_v clears.
  - In RUN, pending is applied only at the boundary edge (cnt==act_period-1). A transfer in the boundary cycle itself is applied at the following boundary.
  - act_period and act_ton never change mid-period.
- State machine IDLE / RUN / STOP:
  - IDLE: clk_out=0, cnt=0. If en=1 → RUN; the first RUN cycle has cnt=0 and period_start=1.
  - RUN:
    - cnt increments and wraps from act_period-1 to 0; period_start=1 when cnt==0.
    - clk_out=0 for cnt in [0, act_period-act_ton-1]; clk_out=1 for cnt in [act_period-act_ton, act_period-1]. Low phase first.
    - The output is registered; it presents the value for the current cnt, with no combinational path from inputs.
    - en=0 → STOP, without truncating the period.
  - STOP: counting continues. At the boundary, go to IDLE with clk_out=0. If en returns to 1 before the boundary → back to RUN, with no gap and no extra period_start.
- Output constraints:
  - No runt pulses: every high pulse is exactly act_ton cycles; every low phase in RUN is exactly act_period-act_ton cycles.
  - busy=1 in RUN and STOP.
- Arithmetic: unsigned CNT_W-bit. act_period-act_ton never underflows, because validation guarantees act_ton < act_period.

Test Plan:
- Default config after reset, en=1 → clk_out repeats 3 low / 7 high; period_start every 10 cycles, aligned to the first low cycle.
- While running at 10/7, send cfg (4,1) in cnt=5 → current period completes as 3L/7H, then 3L/1H repeating. cfg_ready is low from the transfer until the boundary.
- Send cfg (4,1) in the boundary cycle, then cfg (6,3) → (4,1) is applied one period later; cfg_ready blocks (6,3) until then; (6,3) is applied at the next boundary.
- Send cfg (5,0), (1,1) and (5,5) → each is consumed with a cfg_err pulse; active config stays 10/7 and the waveform is unchanged.
- Drop en at cnt=4 of a 10/7 period → high phase completes; IDLE after cnt=9, clk_out=0, busy=0. Re-raising en at cnt=6 instead → continuous waveform.
- Assert rst_n=0 mid-high phase, asynchronous to clk → clk_out=0 immediately. After release with en=1, the waveform restarts at 10/7 from cnt=0.
